univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised N-bit universal shift register, the successor to the plain parallel-in register of the day-8 register series. It adds the following on top of a parallel load:
- left/right logical shift with serial inputs,
- left/right rotate,
- arithmetic right shift,
- synchronous clear,
- global enable,
- a saturating shift counter with a `drained` flag.

It sits between parallel data sources and serial links, acting as a serialiser, deserialiser or barrel-step element.

## Interface
Parameters:
- `N`, default 4: register width in bits; legal range N ≥ 2.
- `CW`, default `$clog2(N+1)`: shift-counter width (derived; not overridden).

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `en`  in  1: global enable. When 0, all state holds regardless of `mode`.
- `mode`  in  3: operation select (see Operation).
- `a`  in  N: parallel load data.
- `sin_lsb`  in  1: serial input entering bit 0 on shift left.
- `sin_msb`  in  1: serial input entering bit N-1 on logical shift right.
- `q`  out  N: register contents (registered).
- `sout_msb`  out  1: combinational copy of `q[N-1]`.
- `sout_lsb`  out  1: combinational copy of `q[0]`.
- `cnt`  out  CW: shift/rotate steps since the last load or clear, saturating at N (registered).
- `drained`  out  1: combinational; 1 when `cnt == N`.

## Operation
Modes, applied on a rising edge of `clk` when `en = 1` and `rst = 1`:
- `000` hold: `q`, `cnt` unchanged.
- `001` load: `q <= a`; `cnt <= 0`.
- `010` shift left: `q <= {q[N-2:0], sin_lsb}`.
- `011` shift right logical: `q <= {sin_msb, q[N-1:1]}`.
- `100` rotate left: `q <= {q[N-2:0], q[N-1]}`.
- `101` rotate right: `q <= {q[0], q[N-1:1]}`.
- `110` arithmetic shift right: `q <= {q[N-1], q[N-1:1]}`.
- `111` clear: `q <= 0`; `cnt <= 0`.

Counter:
- Modes `010`–`110` increment `cnt` by 1 if `cnt < N`.
- At `cnt == N` the counter holds; it does not wrap. `q` still shifts.
- `drained` stays 1 until the next load, clear or reset.

Enable:
- `en = 0` freezes both `q` and `cnt` for every mode, including load and clear.

Serial outputs:
- `sout_msb` is the bit leaving on a shift left.
- `sout_lsb` is the bit leaving on a shift right.
- Both reflect the current `q`, not the next one.

## Timing
- Reset assertion (`rst` falls): immediately, without waiting for a clock, `q = 0`, `cnt = 0`, `drained = 0`, `sout_msb = 0`, `sout_lsb = 0`.
- Reset deassertion: the first rising edge with `rst = 1` performs the selected operation.
- Reset asserted mid-operation (e.g. mid-serialisation) discards all state; there is no partial completion.
- Latency: one cycle. `q`/`cnt` show the result of edge k immediately after edge k.
- `drained`, `sout_msb` and `sout_lsb` follow `q`/`cnt` combinationally, with zero added latency.
- `mode`, `a`, `sin_*` and `en` are sampled only at the rising edge; changes between edges have no effect.
- No handshake: back-to-back operations are legal every cycle, in any order.
- Load while `drained = 1` clears `drained` on the same edge.

## Test plan
- Reset and load:
  - Hold `rst = 0` with `clk` running: `q = 0000`, `cnt = 0`, `drained = 0`.
  - Release `rst`, then `en = 1`, `mode = 001`, `a = 1011`: after 1 edge `q = 1011`, `cnt = 0`.
- Serialise left:
  - From `q = 1011`, apply `mode = 010`, `sin_lsb = 0` for 5 edges.
  - `sout_msb` before each edge = 1, 0, 1, 1.
  - `q` = 0110, 1100, 1000, 0000, 0000.
  - `cnt` = 1, 2, 3, 4, 4; `drained = 1` from the 4th edge onward.
- Rotate and arithmetic shift:
  - Load `1001`; `mode = 100` gives `0011`; `mode = 101` gives `1001`.
  - `mode = 110` twice gives `1100`, then `1110`.
- Enable and clear:
  - Load `0101`, `en = 0`, `mode = 111` for 3 edges: `q` stays `0101`.
  - `en = 1` for 1 edge: `q = 0000`, `cnt = 0`.
- Async reset mid-shift:
  - Load `1111`, shift right with `sin_msb = 1` twice (`cnt = 2`).
  - Pulse `rst` low between edges: `q = 0000` and `cnt = 0` before the next edge.
- Width sweep:
  - Repeat the serialise-left test with N = 2 and N = 8 (`a = 8'hA5`).
  - `drained` must assert after exactly N shifts.

Source files
------------

// File: rtl/univ_shift_reg.sv
// N-bit universal shift register: parallel load, logical/arithmetic shifts, rotates,
// synchronous clear, global enable and a saturating shift-step counter.
module univ_shift_reg #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [2:0]    mode,
  input  logic [N-1:0]  a,
  input  logic          sin_lsb,
  input  logic          sin_msb,
  output logic [N-1:0]  q,
  output logic          sout_msb,
  output logic          sout_lsb,
  output logic [CW-1:0] cnt,
  output logic          drained
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(N);

  logic [N-1:0]  q_next;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_step;

  // Shift/rotate steps saturate at N so drained stays set until load/clear
  assign cnt_step = (cnt < CNT_MAX) ? cnt + CW'(1) : cnt;

  always_comb begin
    q_next   = q;
    cnt_next = cnt;
    if (en) begin
      case (mode)
        M_HOLD: begin
          q_next   = q;
          cnt_next = cnt;
        end
        M_LOAD: begin
          q_next   = a;
          cnt_next = '0;
        end
        M_SHL: begin
          q_next   = {q[N-2:0], sin_lsb};
          cnt_next = cnt_step;
        end
        M_SHR: begin
          q_next   = {sin_msb, q[N-1:1]};
          cnt_next = cnt_step;
        end
        M_ROL: begin
          q_next   = {q[N-2:0], q[N-1]};
          cnt_next = cnt_step;
        end
        M_ROR: begin
          q_next   = {q[0], q[N-1:1]};
          cnt_next = cnt_step;
        end
        M_ASR: begin
          q_next   = {q[N-1], q[N-1:1]};
          cnt_next = cnt_step;
        end
        M_CLR: begin
          q_next   = '0;
          cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      cnt <= '0;
    end else begin
      q   <= q_next;
      cnt <= cnt_next;
    end
  end

  // Serial taps and drained reflect the current register state
  assign sout_msb = q[N-1];
  assign sout_lsb = q[0];
  assign drained  = (cnt == CNT_MAX);

endmodule
